// File: rtl/ripple_carry_adder_dataflow_block.sv
// Registered ripple-carry adder built from an explicit per-bit carry chain.
// Optional V/Z/N status flags are compiled in when RCA_FLAGS_EN is defined.

module rca_bit_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  logic p;

  assign p  = a ^ b;
  assign s  = p ^ ci;
  assign co = (a & b) | (ci & p);
endmodule

module ripple_carry_adder_dataflow_block #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic [WIDTH-1:0] S,
  output logic             Cout
`ifdef RCA_FLAGS_EN
  ,
  output logic             V,
  output logic             Z,
  output logic             N
`endif
);
  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] s;

  assign c[0] = Cin;

  // One cell per bit; carry-out of bit i feeds carry-in of bit i+1.
  rca_bit_cell u_bit [WIDTH-1:0] (
    .a  (A),
    .b  (B),
    .ci (c[WIDTH-1:0]),
    .s  (s),
    .co (c[WIDTH:1])
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      S    <= '0;
      Cout <= 1'b0;
    end else begin
      S    <= s;
      Cout <= c[WIDTH];
    end
  end

`ifdef RCA_FLAGS_EN
  // Signed overflow: carry into the sign bit disagrees with carry out of it.
  always_ff @(posedge clk) begin
    if (rst) begin
      V <= 1'b0;
      Z <= 1'b0;
      N <= 1'b0;
    end else begin
      V <= c[WIDTH] ^ c[WIDTH-1];
      Z <= ~|s;
      N <= s[WIDTH-1];
    end
  end
`endif
endmodule

// File: tb/tb_ripple_carry_adder_dataflow_block.sv
// Directed and random checks of the registered ripple-carry adder at WIDTH=8 and WIDTH=16.
// Flag checks are included when RCA_FLAGS_EN is defined.

module tb_ripple_carry_adder_dataflow_block;
  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  a8, b8, s8;
  logic [15:0] a16, b16, s16;
  logic        cin, cout8, cout16;
`ifdef RCA_FLAGS_EN
  logic        v8, z8, n8, v16, z16, n16;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ripple_carry_adder_dataflow_block #(.WIDTH(8)) u_dut8 (
    .clk  (clk),
    .rst  (rst),
    .A    (a8),
    .B    (b8),
    .Cin  (cin),
    .S    (s8),
    .Cout (cout8)
`ifdef RCA_FLAGS_EN
    ,
    .V    (v8),
    .Z    (z8),
    .N    (n8)
`endif
  );

  ripple_carry_adder_dataflow_block #(.WIDTH(16)) u_dut16 (
    .clk  (clk),
    .rst  (rst),
    .A    (a16),
    .B    (b16),
    .Cin  (cin),
    .S    (s16),
    .Cout (cout16)
`ifdef RCA_FLAGS_EN
    ,
    .V    (v16),
    .Z    (z16),
    .N    (n16)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Drive one operand set, clock it in, and settle 1ns past the edge.
  task automatic step(input logic [7:0] a, input logic [7:0] b, input logic c);
    a8 = a; b8 = b; cin = c;
    @(posedge clk);
    #1;
  endtask

  task automatic chk8(input string tag, input logic [7:0] es, input logic ec);
    chk({tag, ".S"}, {24'd0, s8}, {24'd0, es});
    chk({tag, ".Cout"}, {31'd0, cout8}, {31'd0, ec});
  endtask

`ifdef RCA_FLAGS_EN
  task automatic chkf(input string tag, input logic ev, input logic ez, input logic en);
    chk({tag, ".V"}, {31'd0, v8}, {31'd0, ev});
    chk({tag, ".Z"}, {31'd0, z8}, {31'd0, ez});
    chk({tag, ".N"}, {31'd0, n8}, {31'd0, en});
  endtask
`endif

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       c;
    logic [7:0] s;
    logic       co;
    logic       v;
    logic       z;
    logic       n;
  } vec_t;

  vec_t vecs[$];

  initial begin
    logic [16:0] e16;
    logic [8:0]  e8;

    rst = 1'b1; a16 = 16'h0; b16 = 16'h0;
    // Reset with non-zero operands present: outputs must stay cleared.
    step(8'hAA, 8'h55, 1'b1);
    chk8("rst0", 8'h00, 1'b0);
    step(8'hAA, 8'h55, 1'b1);
    chk8("rst1", 8'h00, 1'b0);
    chk("rst1.S16", {16'd0, s16}, 32'd0);
`ifdef RCA_FLAGS_EN
    chkf("rst1", 1'b0, 1'b0, 1'b0);
`endif
    rst = 1'b0;

    //          a      b      c     s      co    v     z     n
    vecs.push_back('{8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{8'h01, 8'h01, 1'b1, 8'h03, 1'b0, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{8'h02, 8'h03, 1'b0, 8'h05, 1'b0, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{8'h19, 8'h31, 1'b0, 8'h4A, 1'b0, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{8'h03, 8'h03, 1'b1, 8'h07, 1'b0, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{8'hFF, 8'hFF, 1'b0, 8'hFE, 1'b1, 1'b0, 1'b0, 1'b1});
    vecs.push_back('{8'h81, 8'h81, 1'b0, 8'h02, 1'b1, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{8'h40, 8'h40, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0, 1'b1});
    vecs.push_back('{8'h7F, 8'h00, 1'b1, 8'h80, 1'b0, 1'b1, 1'b0, 1'b1});
    vecs.push_back('{8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1});

    foreach (vecs[i]) begin
      step(vecs[i].a, vecs[i].b, vecs[i].c);
      chk8($sformatf("vec%0d", i), vecs[i].s, vecs[i].co);
`ifdef RCA_FLAGS_EN
      chkf($sformatf("vec%0d", i), vecs[i].v, vecs[i].z, vecs[i].n);
`endif
    end

    // Outputs hold between edges even when inputs move.
    step(8'h10, 8'h20, 1'b0);
    a8 = 8'hFF; b8 = 8'hFF; cin = 1'b1;
    #3;
    chk8("hold", 8'h30, 1'b0);

    // Mid-stream reset discards operands, next edge captures normally.
    step(8'hFF, 8'h01, 1'b0);
    chk8("mid.pre", 8'h00, 1'b1);
    rst = 1'b1;
    step(8'hFF, 8'h01, 1'b0);
    chk8("mid.rst", 8'h00, 1'b0);
    rst = 1'b0;
    step(8'h02, 8'h03, 1'b0);
    chk8("mid.post", 8'h05, 1'b0);

    // Random vectors for both widths against an arithmetic reference.
    for (int i = 0; i < 10000; i++) begin
      a8  = 8'($urandom);
      b8  = 8'($urandom);
      a16 = 16'($urandom);
      b16 = 16'($urandom);
      cin = 1'($urandom);
      e8  = {1'b0, a8} + {1'b0, b8} + {8'd0, cin};
      e16 = {1'b0, a16} + {1'b0, b16} + {16'd0, cin};
      @(posedge clk);
      #1;
      chk("rnd8", {23'd0, cout8, s8}, {23'd0, e8});
      chk("rnd16", {15'd0, cout16, s16}, {15'd0, e16});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ripple_carry_adder_dataflow_block.md
RIPPLE_CARRY_ADDER_DATAFLOW_BLOCK -- requirements
Module: ripple_carry_adder_dataflow

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the operand and sum width in bits; legal range is 2 and above.
REQ-002 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge only.
REQ-003 rst  input  1  SHALL be the reset, synchronous and active-high.
REQ-004 A  input  WIDTH  SHALL be operand A, unsigned, or two's complement for the flags.
REQ-005 B  input  WIDTH  SHALL be operand B.
REQ-006 Cin  input  1  SHALL be the carry-in to bit 0.
REQ-007 S  output  WIDTH  SHALL be the registered sum.
REQ-008 Cout  output  1  SHALL be the registered carry-out from bit WIDTH-1.
REQ-009 V, Z, N  output  1 each  SHALL be registered overflow, zero and negative flags; these ports SHALL exist only when RCA_FLAGS_EN is defined (see Configuration).

Function
REQ-010 The adder SHALL be an explicit per-bit ripple chain using continuous assignments, not a single "+" operator:
- c[0] = Cin
- s[i] = A[i] ^ B[i] ^ c[i]
- c[i+1] = (A[i] & B[i]) | (c[i] & (A[i] ^ B[i])), for i = 0..WIDTH-1
REQ-011 The internal carry vector c SHALL be WIDTH+1 bits wide; c[WIDTH] SHALL be the carry-out.
REQ-012 On each rising clk edge with rst low, S SHALL load s[WIDTH-1:0] and Cout SHALL load c[WIDTH], from the A/B/Cin values present before the edge.
REQ-013 Latency SHALL be exactly one cycle.
- There is no handshake: every edge captures the operands.
- Throughput SHALL be one result per cycle.
REQ-014 {Cout,S} SHALL equal A + B + Cin modulo 2^(WIDTH+1) for every input combination. Example: 0xFF + 0xFF + 0 gives Cout=1, S=0xFE.
REQ-015 Wrap-around: a sum of 2^WIDTH or more SHALL set Cout=1 and keep the low WIDTH bits in S.
REQ-016 Outputs SHALL hold their value between edges; input changes between edges SHALL NOT affect S or Cout.
REQ-017 The design SHALL have no latches, no combinational path from inputs to outputs, and no X on outputs after the first reset.

Reset
REQ-018 While rst is high at a rising clk edge, S SHALL be 0 and Cout SHALL be 0.
REQ-019 When flags are compiled in, V, Z and N SHALL also be 0 under the same condition.
REQ-020 Reset SHALL take priority over operand capture; operands present during a reset cycle SHALL be discarded.
REQ-021 Asserting rst mid-stream SHALL clear the outputs at that edge; the first edge with rst low SHALL capture normally.

Configuration
REQ-022 The macro RCA_FLAGS_EN SHALL control the flag outputs.
- Defined: V, Z and N SHALL be present and registered alongside S.
  - V = c[WIDTH] ^ c[WIDTH-1] (signed overflow).
  - Z = 1 when the captured sum bits are all zero.
  - N = s[WIDTH-1].
- Undefined: V, Z and N, and their logic, SHALL be absent; S and Cout behaviour SHALL be unchanged.

Verification
REQ-023 Reset: assert rst for 2 cycles with A=0xAA, B=0x55, Cin=1 -> S=0x00, Cout=0 (and V=Z=N=0 if flags are compiled in).
REQ-024 Basic sums, one result per cycle with 1-cycle latency:
- 0x01+0x01+0 -> S=0x02, Cout=0
- 0x01+0x01+1 -> S=0x03
- 0x02+0x03 -> S=0x05
- 0x19+0x31 -> S=0x4A
- 0x03+0x03+1 -> S=0x07
REQ-025 Carry rip and wrap:
- 0xFF+0x01+0 -> S=0x00, Cout=1 (Z=1)
- 0xFF+0x00+1 -> S=0x00, Cout=1
- 0xFF+0xFF+0 -> S=0xFE, Cout=1 (N=1, V=0)
REQ-026 Signed overflow, flags compiled in: 0x81+0x81 -> S=0x02, Cout=1, V=1, N=0; 0x40+0x40 -> S=0x80, Cout=0, V=1, N=1.
REQ-027 Reset mid-stream: drive 0xFF+0x01, assert rst for one edge, then drive 0x02+0x03 -> S=0x00/Cout=0 at the reset edge, then S=0x05/Cout=0 at the next edge.
REQ-028 Random: at least 10,000 random A/B/Cin vectors for WIDTH=8 and WIDTH=16 SHALL each match {Cout,S} = A+B+Cin one cycle later.
